// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC / IF-ID / ID-EX enables and flushes, plus perf counters.
// Latency: controls are combinational from state + inputs; counters update one cycle later.
// Backpressure: mem_busy freezes the whole pipeline and takes priority over every other event.
module hazard_ctrl #(
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_jump,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_wr_reg,
    input  logic             EX_branch_taken,
    input  logic             mem_busy,
    output logic             PC_wr_en,
    output logic             IF_ID_wr_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_MEM_WAIT} state_t;

    state_t     state, state_nxt, ret_state, ret_nxt, eff_state;
    logic [3:0] lu_cnt, lu_cnt_nxt;
    logic       lu_hit;

    assign lu_hit = EX_mem_read && (EX_wr_reg != 5'd0) &&
                    ((EX_wr_reg == ID_rs) || (ID_uses_rt && (EX_wr_reg == ID_rt)));

    always_comb begin
        PC_wr_en    = 1'b1;
        IF_ID_wr_en = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        ret_nxt     = ret_state;
        lu_cnt_nxt  = lu_cnt;
        // Leaving MEM_WAIT applies the return state's rules in the same cycle.
        eff_state   = (state == S_MEM_WAIT) ? ret_state : state;

        if (mem_busy) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            pipe_freeze = 1'b1;
            if (state != S_MEM_WAIT) ret_nxt = state;
            state_nxt   = S_MEM_WAIT;
        end else begin
            case (eff_state)
                S_LU_STALL: begin
                    state_nxt = S_LU_STALL;
                    if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        lu_cnt_nxt  = 4'd0;
                        state_nxt   = S_RUN;
                    end else begin
                        PC_wr_en    = 1'b0;
                        IF_ID_wr_en = 1'b0;
                        ID_EX_flush = 1'b1;
                        lu_cnt_nxt  = lu_cnt - 4'd1;
                        if (lu_cnt <= 4'd1) state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                    if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (lu_hit) begin
                        PC_wr_en    = 1'b0;
                        IF_ID_wr_en = 1'b0;
                        ID_EX_flush = 1'b1;
                        if (LU_STALL > 1) begin
                            lu_cnt_nxt = 4'(LU_STALL - 1);
                            state_nxt  = S_LU_STALL;
                        end
                    end else if (ID_jump) begin
                        IF_ID_flush = 1'b1;
                    end
                end
            endcase
        end

        if (!reset) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            IF_ID_flush = 1'b0;
            ID_EX_flush = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_RUN;
            ret_state    <= S_RUN;
            lu_cnt       <= 4'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lu_cnt    <= lu_cnt_nxt;
            if (!PC_wr_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (IF_ID_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LU_STALL=1, LU_STALL=3, CNT_W=4) share stimulus.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, EX_wr_reg;
    logic       ID_uses_rt, ID_jump, EX_mem_read, EX_branch_taken, mem_busy;

    logic        pc1, ifwr1, iff1, idf1, frz1;
    logic [15:0] st1, fc1;
    logic        pc3, ifwr3, iff3, idf3, frz3;
    logic [15:0] st3, fc3;
    logic        pc4, ifwr4, iff4, idf4, frz4;
    logic [3:0]  st4, fc4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) u_lu1 (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_jump(ID_jump), .EX_mem_read(EX_mem_read), .EX_wr_reg(EX_wr_reg),
        .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
        .PC_wr_en(pc1), .IF_ID_wr_en(ifwr1), .IF_ID_flush(iff1), .ID_EX_flush(idf1),
        .pipe_freeze(frz1), .stall_cycles(st1), .flush_count(fc1));

    hazard_ctrl #(.LU_STALL(3), .CNT_W(16)) u_lu3 (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_jump(ID_jump), .EX_mem_read(EX_mem_read), .EX_wr_reg(EX_wr_reg),
        .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
        .PC_wr_en(pc3), .IF_ID_wr_en(ifwr3), .IF_ID_flush(iff3), .ID_EX_flush(idf3),
        .pipe_freeze(frz3), .stall_cycles(st3), .flush_count(fc3));

    hazard_ctrl #(.LU_STALL(3), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_jump(ID_jump), .EX_mem_read(EX_mem_read), .EX_wr_reg(EX_wr_reg),
        .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
        .PC_wr_en(pc4), .IF_ID_wr_en(ifwr4), .IF_ID_flush(iff4), .ID_EX_flush(idf4),
        .pipe_freeze(frz4), .stall_cycles(st4), .flush_count(fc4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; ID_jump = 1'b0;
        EX_mem_read = 1'b0; EX_wr_reg = 5'd0; EX_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use();
        ID_rs = 5'd5; EX_mem_read = 1'b1; EX_wr_reg = 5'd5;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // 1: reset values for 3 cycles, then run defaults
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pc", pc3, 0);
            check("rst_ifwr", ifwr3, 0);
            check("rst_flush", {iff3, idf3, frz3}, 0);
            check("rst_cnt", {st3, fc3}, 0);
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        check("run_pc", pc3, 1);
        check("run_ifwr", ifwr3, 1);
        check("run_cnt", {st3, fc3}, 0);
        tick();

        // 2: load-use, 1 bubble vs 3 bubbles
        load_use();
        @(negedge clk);
        check("lu1_pc", pc1, 0);
        check("lu1_idf", idf1, 1);
        check("lu3_pc_a", pc3, 0);
        tick();
        idle();
        @(negedge clk);
        check("lu1_pc_done", pc1, 1);
        check("lu1_idf_done", idf1, 0);
        check("lu3_pc_b", pc3, 0);
        check("lu3_idf_b", idf3, 1);
        tick();
        @(negedge clk);
        check("lu3_pc_c", pc3, 0);
        tick();
        @(negedge clk);
        check("lu3_pc_done", pc3, 1);
        check("lu3_stalls", st3, 3);
        check("lu1_stalls", st1, 1);
        tick();

        // 3: branch on the 2nd stall cycle aborts the stall
        load_use();
        tick();
        idle();
        EX_branch_taken = 1'b1;
        @(negedge clk);
        check("br_pc", pc3, 1);
        check("br_iff", iff3, 1);
        check("br_idf", idf3, 1);
        tick();
        idle();
        @(negedge clk);
        check("br_run_pc", pc3, 1);
        check("br_run_idf", idf3, 0);
        check("br_fc", fc3, 1);
        check("br_stalls", st3, 4);
        tick();

        // 4: mem_busy for 4 cycles with lu_cnt=2, then 2 remaining bubbles
        load_use();
        tick();
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mw_frz", frz3, 1);
            check("mw_en", {pc3, ifwr3, iff3, idf3}, 0);
            tick();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mw_bub", {pc3, ifwr3, idf3, frz3}, 4'b0010);
            tick();
        end
        @(negedge clk);
        check("mw_run", {pc3, ifwr3, idf3, frz3}, 4'b1100);
        tick();

        // reset mid-stall drops pending bubbles
        load_use();
        tick();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pc", pc3, 1);
        tick();

        // 5: jump with x0 load in EX is not a hazard
        do_reset();
        ID_jump = 1'b1; EX_mem_read = 1'b1; EX_wr_reg = 5'd0; ID_rs = 5'd0;
        @(negedge clk);
        check("jmp_pc", pc3, 1);
        check("jmp_iff", iff3, 1);
        check("jmp_idf", idf3, 0);
        tick();
        idle();
        @(negedge clk);
        check("jmp_fc", fc3, 1);
        check("jmp_st", st3, 0);
        tick();

        // jump coincident with a load-use stall is ignored that cycle
        ID_jump = 1'b1; load_use();
        @(negedge clk);
        check("jmp_lu_iff", iff1, 0);
        check("jmp_lu_pc", pc1, 0);
        tick();

        // rt hazard only counts when ID_uses_rt
        idle();
        ID_rt = 5'd7; EX_mem_read = 1'b1; EX_wr_reg = 5'd7;
        @(negedge clk);
        check("rt_unused", pc1, 1);
        ID_uses_rt = 1'b1;
        #1;
        check("rt_used", pc1, 0);
        tick();

        // 6: 4-bit stall counter saturates
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 14) check("sat_pre", st4, 14);
            tick();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check("sat_c4", st4, 15);
        check("sat_c16", st3, 20);
        check("sat_exit_pc", pc4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
